// File: rtl/lift_req_queue.sv
// Hall-call request capture and FIFO: edge-detects button levels into sticky pending
// bits and queues one request code per cycle. Optional macro: LIFT_REQ_DEDUP_EN.
module lift_req_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] btn,
    input  logic       done,
    output logic [2:0] req_code,
    output logic       q_empty,
    output logic       q_full,
    output logic [3:0] q_count
);

    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

    function automatic logic [2:0] idx2code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = 3'b001;
            3'd1:    code = 3'b010;
            3'd2:    code = 3'b011;
            3'd3:    code = 3'b110;
            3'd4:    code = 3'b111;
            3'd5:    code = 3'b100;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    function automatic logic [5:0] code2mask(input logic [2:0] code);
        logic [5:0] m;
        case (code)
            3'b001:  m = 6'b000001;
            3'b010:  m = 6'b000010;
            3'b011:  m = 6'b000100;
            3'b110:  m = 6'b001000;
            3'b111:  m = 6'b010000;
            3'b100:  m = 6'b100000;
            default: m = '0;
        endcase
        return m;
    endfunction

    logic [5:0]    btn_q;
    logic [5:0]    pend_q, pend_d;
    logic [5:0]    inq_q, inq_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    logic [2:0]    mem_q [DEPTH];

    logic [5:0]    rise;
    logic [5:0]    sel_mask;
    logic          cand_valid;
    logic [2:0]    cand_idx;
    logic          do_push;
    logic          do_pop;
    logic [5:0]    push_mask;
    logic [5:0]    pop_mask;
    logic [2:0]    push_code;

    always_comb begin
        rise = btn & ~btn_q;

`ifdef LIFT_REQ_DEDUP_EN
        sel_mask = pend_q & ~inq_q;
`else
        sel_mask = pend_q;
`endif

        cand_valid = 1'b0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (sel_mask[i] && !cand_valid) begin
                cand_valid = 1'b1;
                cand_idx   = 3'(i);
            end
        end

        // Full check uses the registered count, so a same-cycle pop never frees a slot early.
        do_push   = cand_valid && (count_q < DEPTH_C);
        do_pop    = done && (count_q != '0);
        push_code = idx2code(cand_idx);
        push_mask = do_push ? (6'(1) << cand_idx) : '0;
        pop_mask  = do_pop ? code2mask(mem_q[rd_ptr_q]) : '0;

        // A fresh rise in the push cycle survives the clear and becomes a new request.
        pend_d = (pend_q & ~push_mask) | rise;
        inq_d  = (inq_q & ~pop_mask) | push_mask;

        wr_ptr_d = do_push ? PW'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? PW'(rd_ptr_q + 1'b1) : rd_ptr_q;

        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q    <= '1;
            pend_q   <= '0;
            inq_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            btn_q    <= btn;
            pend_q   <= pend_d;
            inq_q    <= inq_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wr_ptr_q] <= push_code;
        end
    end

    assign q_empty  = (count_q == '0);
    assign q_full   = (count_q == DEPTH_C);
    assign q_count  = count_q;
    assign req_code = q_empty ? 3'b000 : mem_q[rd_ptr_q];

endmodule
